// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared definitions for the load/store unit.
//   - FSM state encoding
//   - mem_op field positions {is_mem, is_store, size[1:0]} and size codes
//   - NOP register index / zero word constants
//   - size_mask(): byte-lane mask for an access size
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_OUT  = 2'd3
    } lsu_state_e;

    localparam int MOP_IS_MEM   = 3;
    localparam int MOP_IS_STORE = 2;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    localparam int          NOP_REG_ADDR = 0;
    localparam logic [63:0] ZERO_WORD    = 64'h0;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 8'h01;
            SZ_HALF: return 8'h03;
            SZ_WORD: return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: combinational lane handling for mem_lsu.
// Ports:
//   addr_i, size_i, sdata_i  request-side address/size/store data
//   misalign_o               address not naturally aligned for size (or dword on XLEN=32)
//   daddr_o                  address with byte-offset bits cleared
//   wstrb_o, wdata_o         store strobe and store data moved onto their byte lanes
//   ld_off_i, ld_size_i,
//   ld_uns_i, rdata_i        load-side offset/size/extension and raw bus data
//   ldata_o                  load result, right-aligned and sign/zero extended
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter  int XLEN   = 64,
    localparam int STRB_W = XLEN / 8,
    localparam int OFF_W  = $clog2(STRB_W)
) (
    input  logic [XLEN-1:0]   addr_i,
    input  logic [1:0]        size_i,
    input  logic [XLEN-1:0]   sdata_i,
    output logic              misalign_o,
    output logic [XLEN-1:0]   daddr_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [XLEN-1:0]   wdata_o,
    input  logic [OFF_W-1:0]  ld_off_i,
    input  logic [1:0]        ld_size_i,
    input  logic              ld_uns_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   ldata_o
);

    logic [OFF_W-1:0]  off;
    logic [7:0]        mask8;
    logic [STRB_W-1:0] mask;
    logic [XLEN-1:0]   shifted;
    int                width;
    logic              sbit;

    assign off     = addr_i[OFF_W-1:0];
    assign mask8   = size_mask(size_i);
    assign mask    = mask8[STRB_W-1:0];
    assign wstrb_o = mask << off;
    assign wdata_o = sdata_i << {off, 3'b000};
    assign daddr_o = {addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign shifted = rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        case (size_i)
            SZ_BYTE: misalign_o = 1'b0;
            SZ_HALF: misalign_o = addr_i[0];
            SZ_WORD: misalign_o = |addr_i[1:0];
            default: misalign_o = (XLEN == 32) || (|addr_i[2:0]);
        endcase
    end

    // Bits above the access width take the extension bit; a full-width
    // access passes through untouched.
    always_comb begin
        case (ld_size_i)
            SZ_BYTE: begin width = 8;    sbit = shifted[7];  end
            SZ_HALF: begin width = 16;   sbit = shifted[15]; end
            SZ_WORD: begin width = 32;   sbit = shifted[31]; end
            default: begin width = XLEN; sbit = 1'b0;        end
        endcase
        for (int i = 0; i < XLEN; i++) begin
            ldata_o[i] = (i < width) ? shifted[i] : (sbit & ~ld_uns_i);
        end
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM pipeline stage. Accepts an op from EX, performs an optional
// data-memory access and presents the result to WB.
// Ports:
//   clk, rst                      clock, async active-high reset
//   valid_i/ready_o, wd_i, wreg_i,
//   wdata_i, mem_op_i, unsigned_i,
//   sdata_i                       EX->MEM handshake and payload
//   dreq_o/dready_i, daddr_o,
//   dwen_o, dwdata_o, dwstrb_o    data-memory request channel
//   drvalid_i, drdata_i           data-memory response channel
//   valid_o/ready_i, wd_o, wreg_o,
//   wdata_o, misalign_o           MEM->WB handshake and payload
//
// state  | meaning
// IDLE   | empty, ready for a new op
// REQ    | memory request presented, waiting for dready_i
// RESP   | waiting for drvalid_i
// OUT    | result presented to WB, held until ready_i
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [RADDR_W-1:0]   wd_i,
    input  logic                 wreg_i,
    input  logic [XLEN-1:0]      wdata_i,
    input  logic [3:0]           mem_op_i,
    input  logic                 unsigned_i,
    input  logic [XLEN-1:0]      sdata_i,
    output logic                 dreq_o,
    input  logic                 dready_i,
    output logic [XLEN-1:0]      daddr_o,
    output logic                 dwen_o,
    output logic [XLEN-1:0]      dwdata_o,
    output logic [XLEN/8-1:0]    dwstrb_o,
    input  logic                 drvalid_i,
    input  logic [XLEN-1:0]      drdata_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [RADDR_W-1:0]   wd_o,
    output logic                 wreg_o,
    output logic [XLEN-1:0]      wdata_o,
    output logic                 misalign_o
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    lsu_state_e         state_q;
    logic               valid_q, dreq_q, dwen_q, wreg_q, misalign_q;
    logic [RADDR_W-1:0] wd_q;
    logic [XLEN-1:0]    wdata_q, daddr_q, dwdata_q;
    logic [STRB_W-1:0]  dwstrb_q;
    logic [OFF_W-1:0]   ld_off_q;
    logic [1:0]         ld_size_q;
    logic               ld_uns_q, st_q;

    logic               is_mem, is_store, accept;
    logic               a_mis;
    logic [XLEN-1:0]    a_daddr, a_wdata, a_ldata;
    logic [STRB_W-1:0]  a_wstrb;

    assign is_mem   = mem_op_i[MOP_IS_MEM];
    assign is_store = mem_op_i[MOP_IS_STORE];
    assign ready_o  = (state_q == S_IDLE) || ((state_q == S_OUT) && ready_i);
    assign accept   = valid_i && ready_o;

    mem_lsu_align #(.XLEN(XLEN)) u_align (
        .addr_i     (wdata_i),
        .size_i     (mem_op_i[1:0]),
        .sdata_i    (sdata_i),
        .misalign_o (a_mis),
        .daddr_o    (a_daddr),
        .wstrb_o    (a_wstrb),
        .wdata_o    (a_wdata),
        .ld_off_i   (ld_off_q),
        .ld_size_i  (ld_size_q),
        .ld_uns_i   (ld_uns_q),
        .rdata_i    (drdata_i),
        .ldata_o    (a_ldata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b0;
            dreq_q     <= 1'b0;
            dwen_q     <= 1'b0;
            wreg_q     <= 1'b0;
            misalign_q <= 1'b0;
            wd_q       <= RADDR_W'(NOP_REG_ADDR);
            wdata_q    <= XLEN'(ZERO_WORD);
            daddr_q    <= XLEN'(ZERO_WORD);
            dwdata_q   <= XLEN'(ZERO_WORD);
            dwstrb_q   <= '0;
            ld_off_q   <= '0;
            ld_size_q  <= SZ_BYTE;
            ld_uns_q   <= 1'b0;
            st_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_OUT: begin
                    if (accept) begin
                        wd_q       <= wd_i;
                        misalign_q <= 1'b0;
                        ld_off_q   <= wdata_i[OFF_W-1:0];
                        ld_size_q  <= mem_op_i[1:0];
                        ld_uns_q   <= unsigned_i;
                        st_q       <= is_store;
                        if (!is_mem) begin
                            state_q <= S_OUT;
                            valid_q <= 1'b1;
                            wreg_q  <= wreg_i;
                            wdata_q <= wdata_i;
                        end else if (a_mis) begin
                            state_q    <= S_OUT;
                            valid_q    <= 1'b1;
                            wreg_q     <= 1'b0;
                            wdata_q    <= XLEN'(ZERO_WORD);
                            misalign_q <= 1'b1;
                        end else begin
                            state_q  <= S_REQ;
                            valid_q  <= 1'b0;
                            wreg_q   <= wreg_i & ~is_store;
                            dreq_q   <= 1'b1;
                            daddr_q  <= a_daddr;
                            dwen_q   <= is_store;
                            dwdata_q <= is_store ? a_wdata : XLEN'(ZERO_WORD);
                            dwstrb_q <= is_store ? a_wstrb : '0;
                        end
                    end else if ((state_q == S_OUT) && ready_i) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (dready_i) begin
                        state_q <= S_RESP;
                        dreq_q  <= 1'b0;
                        dwen_q  <= 1'b0;
                    end
                end
                S_RESP: begin
                    if (drvalid_i) begin
                        state_q <= S_OUT;
                        valid_q <= 1'b1;
                        wdata_q <= st_q ? XLEN'(ZERO_WORD) : a_ldata;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign valid_o    = valid_q;
    assign dreq_o     = dreq_q;
    assign daddr_o    = daddr_q;
    assign dwen_o     = dwen_q;
    assign dwdata_o   = dwdata_q;
    assign dwstrb_o   = dwstrb_q;
    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, wreg_i, unsigned_i;
    logic [4:0]  wd_i, wd_o;
    logic [63:0] wdata_i, sdata_i, daddr_o, dwdata_o, drdata_i, wdata_o;
    logic [3:0]  mem_op_i;
    logic        dreq_o, dready_i, dwen_o, drvalid_i, valid_o, ready_i, wreg_o, misalign_o;
    logic [7:0]  dwstrb_o;

    always #5 clk = ~clk;

    mem_lsu #(.XLEN(64), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .valid_i(valid_i), .ready_o(ready_o), .wd_i(wd_i), .wreg_i(wreg_i),
        .wdata_i(wdata_i), .mem_op_i(mem_op_i), .unsigned_i(unsigned_i), .sdata_i(sdata_i),
        .dreq_o(dreq_o), .dready_i(dready_i), .daddr_o(daddr_o), .dwen_o(dwen_o),
        .dwdata_o(dwdata_o), .dwstrb_o(dwstrb_o), .drvalid_i(drvalid_i), .drdata_i(drdata_i),
        .valid_o(valid_o), .ready_i(ready_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .misalign_o(misalign_o)
    );

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [63:0] wdata;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   n_chk = 0, n_pass = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Memory responder: grants after 'dly' extra request cycles, answers one cycle later.
    int          dly = 0, wcnt = 0, dreq_cnt = 0, stab_err = 0;
    bit          auto_en = 1'b1, force_drv = 1'b0, first = 1'b1;
    logic        auto_drv;
    logic [63:0] rdata_val, f_addr, f_wdata;
    logic [7:0]  f_strb;
    logic        f_wen;

    assign drvalid_i = auto_drv | force_drv;
    assign drdata_i  = rdata_val;

    initial begin
        dready_i = 1'b0;
        auto_drv = 1'b0;
        forever begin
            @(negedge clk);
            auto_drv = 1'b0;
            if (dready_i) begin
                dready_i = 1'b0;
                auto_drv = auto_en;
                wcnt     = 0;
                first    = 1'b1;
            end else if (dreq_o) begin
                dreq_cnt++;
                if (first) begin
                    f_addr = daddr_o; f_wdata = dwdata_o; f_strb = dwstrb_o; f_wen = dwen_o;
                    first  = 1'b0;
                end else if (f_addr !== daddr_o || f_wdata !== dwdata_o ||
                             f_strb !== dwstrb_o || f_wen !== dwen_o) begin
                    stab_err++;
                end
                if (wcnt >= dly) dready_i = 1'b1;
                else wcnt++;
            end
        end
    end

    // Monitor: every WB transfer is checked against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_valid: got wd=%0d wdata=0x%0h expected no output", wd_o, wdata_o);
                end else begin
                    e = sb.pop_front();
                    chk("out_wd", 64'(wd_o), 64'(e.wd));
                    chk("out_wreg", 64'(wreg_o), 64'(e.wreg));
                    chk("out_wdata", wdata_o, e.wdata);
                    chk("out_misalign", 64'(misalign_o), 64'(e.mis));
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    // Entered and left at posedge+1; returns just after the accepting edge.
    task automatic send(input logic [4:0] wd, input logic wreg, input logic [63:0] wdata,
                        input logic [3:0] op, input logic uns, input logic [63:0] sdata,
                        input logic ewreg, input logic [63:0] ewdata, input logic emis,
                        input bit push);
        bit rdy;
        int n = 0;
        if (push) sb.push_back('{wd: wd, wreg: ewreg, wdata: ewdata, mis: emis});
        wd_i = wd; wreg_i = wreg; wdata_i = wdata; mem_op_i = op; unsigned_i = uns; sdata_i = sdata;
        valid_i = 1'b1;
        do begin
            @(negedge clk);
            rdy = ready_o;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        valid_i = 1'b0;
        if (!rdy) begin
            n_chk++;
            $display("FAIL send_timeout: got ready_o=0 expected 1");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        int base, stab0;
        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0; mem_op_i = '0; unsigned_i = 1'b0; sdata_i = '0;
        rdata_val = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 64'({valid_o, dreq_o, dwen_o, wreg_o, misalign_o}), 64'h0);
        chk("rst_wdata", wdata_o, 64'h0);
        chk("rst_daddr", daddr_o, 64'h0);
        chk("rst_dwdata", dwdata_o, 64'h0);
        chk("rst_wd_strb", 64'({wd_o, dwstrb_o}), 64'h0);
        chk("rst_ready", 64'(ready_o), 64'h1);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU op: one-cycle latency
        send(5'd5, 1'b1, 64'h1234, 4'b0000, 1'b0, 64'h0, 1'b1, 64'h1234, 1'b0, 1'b1);
        chk("alu_latency", 64'(valid_o), 64'h1);
        wait_idle();

        // Loads
        rdata_val = 64'h0000_0000_8000_0000;
        send(5'd7, 1'b1, 64'h1003, 4'b1000, 1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b1);
        wait_idle();
        send(5'd7, 1'b1, 64'h1003, 4'b1000, 1'b1, 64'h0, 1'b1, 64'h80, 1'b0, 1'b1);
        wait_idle();
        rdata_val = 64'h0000_0000_F234_0000;
        send(5'd8, 1'b1, 64'h100A, 4'b1001, 1'b0, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_F234, 1'b0, 1'b1);
        wait_idle();
        rdata_val = 64'h89AB_CDEF_0000_0000;
        send(5'd9, 1'b1, 64'h1004, 4'b1010, 1'b1, 64'h0, 1'b1, 64'h89AB_CDEF, 1'b0, 1'b1);
        wait_idle();
        rdata_val = 64'h1122_3344_5566_7788;
        send(5'd10, 1'b1, 64'h1008, 4'b1011, 1'b0, 64'h0, 1'b1, 64'h1122_3344_5566_7788, 1'b0, 1'b1);
        wait_idle();

        // Half store with 3 wait cycles
        dly = 3; base = dreq_cnt; stab0 = stab_err;
        send(5'd11, 1'b1, 64'h2006, 4'b1101, 1'b0, 64'hABCD, 1'b0, 64'h0, 1'b0, 1'b1);
        wait_idle();
        chk("st_dreq_cycles", 64'(dreq_cnt - base), 64'd4);
        chk("st_strb", 64'(f_strb), 64'hC0);
        chk("st_wdata", f_wdata, 64'hABCD_0000_0000_0000);
        chk("st_daddr", f_addr, 64'h2000);
        chk("st_wen", 64'(f_wen), 64'h1);
        chk("st_stable", 64'(stab_err - stab0), 64'h0);
        dly = 0;

        // Misaligned word load: no request
        base = dreq_cnt;
        send(5'd3, 1'b1, 64'h1002, 4'b1010, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 1'b1);
        wait_idle();
        chk("mis_no_dreq", 64'(dreq_cnt - base), 64'h0);

        // Back-to-back ALU ops with WB stalled for 2 cycles
        ready_i = 1'b0;
        send(5'd1, 1'b1, 64'h111, 4'b0000, 1'b0, 64'h0, 1'b1, 64'h111, 1'b0, 1'b1);
        sb.push_back('{wd: 5'd2, wreg: 1'b1, wdata: 64'h222, mis: 1'b0});
        wd_i = 5'd2; wreg_i = 1'b1; wdata_i = 64'h222; mem_op_i = 4'b0000; valid_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_ready", 64'(ready_o), 64'h0);
            chk("stall_valid", 64'(valid_o), 64'h1);
            chk("stall_payload", wdata_o, 64'h111);
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        valid_i = 1'b0;
        wait_idle();
        if (pop_cyc.size() >= 2) chk("b2b_consecutive", 64'(pop_cyc[$] - pop_cyc[$-1]), 64'h1);
        else begin
            n_chk++;
            $display("FAIL b2b_consecutive: got %0d retirements expected at least 2", pop_cyc.size());
        end

        // Reset while in RESP, then a late drvalid
        auto_en = 1'b0; rdata_val = 64'hDEAD;
        send(5'd4, 1'b1, 64'h1000, 4'b1011, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_resp_out", 64'({valid_o, dreq_o}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0; force_drv = 1'b1;
        @(negedge clk);
        chk("late_drvalid_valid", 64'(valid_o), 64'h0);
        @(posedge clk); #1;
        force_drv = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 64'({ready_o, valid_o}), 64'h2);
        auto_en = 1'b1;
        @(posedge clk); #1;
        send(5'd6, 1'b1, 64'h55, 4'b0000, 1'b0, 64'h0, 1'b1, 64'h55, 1'b0, 1'b1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter XLEN, default 64, SHALL set the data/address width; legal values are 32 and 64.
REQ-002 Parameter RADDR_W, default 5, SHALL set the destination-register index width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: asynchronous assert, active-high.
REQ-005 valid_i  in  1; ready_o  out  1  SHALL form the EX->MEM handshake; transfer occurs when both are high.
REQ-006 wd_i  in  RADDR_W; wreg_i  in  1; wdata_i  in  XLEN  SHALL carry the destination index, write enable, and ALU result (effective address for memory ops).
REQ-007 mem_op_i  in  4  SHALL carry {is_mem, is_store, size[1:0]}; unsigned_i  in  1 selects zero-extension for loads; sdata_i  in  XLEN is the store data.
REQ-008 dreq_o  out  1; dready_i  in  1; daddr_o  out  XLEN; dwen_o  out  1; dwdata_o  out  XLEN; dwstrb_o  out  XLEN/8  SHALL form the data-memory request channel.
REQ-009 drvalid_i  in  1; drdata_i  in  XLEN  SHALL form the response channel, including the store acknowledge.
REQ-010 valid_o  out  1; ready_i  in  1; wd_o  out  RADDR_W; wreg_o  out  1; wdata_o  out  XLEN; misalign_o  out  1  SHALL form the MEM->WB handshake and payload.

Function
REQ-011 The FSM SHALL have four states: IDLE, REQ, RESP, OUT.
REQ-012 ready_o SHALL be high in IDLE, and high in OUT when ready_i=1; it SHALL be low otherwise.
REQ-013 An accepted non-memory op (is_mem=0) SHALL enter OUT next cycle with wdata_o=wdata_i, wd_o=wd_i, wreg_o=wreg_i.
REQ-014 An accepted aligned memory op SHALL enter REQ; dreq_o SHALL stay high with stable daddr_o, dwen_o, dwdata_o, dwstrb_o until dready_i=1, then the FSM SHALL go to RESP.
REQ-015 RESP SHALL wait for drvalid_i; on drvalid_i=1 it SHALL register the result and go to OUT.
REQ-016 Alignment SHALL be by size: 00 byte, 01 half, 10 word, 11 dword. An address with nonzero low bits for its size, or size 11 when XLEN=32, SHALL be misaligned.
REQ-017 A misaligned op SHALL issue no memory request and SHALL go directly to OUT with misalign_o=1 and wreg_o=0.
REQ-018 daddr_o SHALL be the address with its low log2(XLEN/8) bits cleared.
REQ-019 The store strobe dwstrb_o SHALL be the size mask (1, 3, 0xF, 0xFF bytes) shifted left by the byte offset; dwdata_o SHALL be sdata_i shifted left by offset*8.
REQ-020 Load data SHALL be drdata_i shifted right by offset*8, truncated to size, then sign- or zero-extended per unsigned_i.
REQ-021 Stores SHALL reach OUT with wreg_o=0 and wdata_o=0.
REQ-022 In OUT, valid_o SHALL be 1 and the payload SHALL be held until ready_i=1. With ready_i=1 and valid_i=1 in the same cycle, the new op SHALL be accepted (zero-bubble); with ready_i=1 and valid_i=0 the FSM SHALL return to IDLE.
REQ-023 drvalid_i outside RESP SHALL be ignored; dready_i outside REQ SHALL be ignored.
REQ-024 Latency SHALL be 1 cycle for a non-memory op, and 2 cycles plus memory wait for a memory op.

Reset
REQ-025 On rst=1 the FSM SHALL go to IDLE and valid_o, dreq_o, dwen_o, wreg_o, misalign_o SHALL be 0; wd_o, wdata_o, daddr_o, dwdata_o, dwstrb_o SHALL be 0.
REQ-026 Reset mid-REQ or mid-RESP SHALL abandon the transaction; a late drvalid_i after reset SHALL be ignored per REQ-023.

Structure
REQ-027 The mem_op field encodings, size codes, FSM state encodings, and NOPRegAddr/ZeroWord constants SHALL live in the shared defines file.
REQ-028 Lane shifting, strobe generation, and load extension SHALL be one combinational sub-module, mem_lsu_align; the FSM and registers SHALL be in mem_lsu.

Verification
REQ-029 ALU op, wd_i=5, wreg_i=1, wdata_i=0x1234, ready_i=1 -> next cycle valid_o=1, wd_o=5, wdata_o=0x1234.
REQ-030 Signed byte load at 0x1003, drdata_i=0x0000_0000_8000_0000 -> wdata_o=0xFFFF_FFFF_FFFF_FF80; the unsigned variant -> 0x80.
REQ-031 Half store at 0x2006, sdata_i=0xABCD, dready_i delayed 3 cycles -> dreq_o held 4 cycles, dwstrb_o=0xC0, dwdata_o=0xABCD_0000_0000_0000, wreg_o=0.
REQ-032 Word load at 0x1002 -> dreq_o never asserted, misalign_o=1, wreg_o=0.
REQ-033 Two back-to-back ALU ops with ready_i=0 for 2 cycles -> first payload stable and ready_o=0 throughout; both ops then retire in consecutive cycles.
REQ-034 Assert rst while in RESP, then drvalid_i=1 -> valid_o stays 0, FSM in IDLE, and the next op behaves normally.
